serv_mem_arbiter: RTL and testbench

Registered two-to-one arbiter that shares a single Wishbone-style memory port between the SERV instruction bus and data bus. It sits between the `serv_rf_top` bus outputs and the single-port memory/AXI bridge slave. It latches the winning request, holds the downstream cycle until acknowledge, and returns registered ack and read data to the granted requester. An optional watchdog terminates stalled transactions.

---
 rtl/serv_mem_arbiter_pkg.sv | 33 +++
 rtl/serv_arb_wdt.sv | 43 ++++
 rtl/serv_mem_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_serv_mem_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/serv_mem_arbiter_pkg.sv
// Shared definitions for the SERV ibus/dbus memory arbiter: FSM encodings,
// grant constants and the grant-selection helper.
package serv_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_ACK  = 2'd2
    } arb_state_e;

    localparam logic       GNT_I    = 1'b0;
    localparam logic       GNT_D    = 1'b1;
    localparam logic [3:0] SEL_WORD = 4'hF;

    // With both buses requesting, fair mode hands the grant to whoever lost last time
    function automatic logic arb_pick(input logic ibus_req, input logic dbus_req,
                                      input logic fair, input logic last);
        logic win;
        if (ibus_req && dbus_req) begin
            if (fair) begin
                win = ~last;
            end else begin
                win = GNT_D;
            end
        end else if (dbus_req) begin
            win = GNT_D;
        end else begin
            win = GNT_I;
        end
        return win;
    endfunction

endpackage

// File: rtl/serv_arb_wdt.sv
// Saturating watchdog for the arbiter: counts BUSY cycles without ack and
// flags expiry on the cycle whose edge would bring the count to TIMEOUT.
module serv_arb_wdt #(
    parameter int TIMEOUT = 1
) (
    input  logic clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expire
);

    localparam int             W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [W-1:0]   LIMIT = W'(TIMEOUT);
    localparam logic [W-1:0]   LAST  = W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    logic [W-1:0] count_d;
    logic [W-1:0] count_q;

    // Next count: clear on grant, step while stalled, hold at the limit
    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = {W{1'b0}};
        end else if (i_en && (count_q != LIMIT)) begin
            count_d = count_q + W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (i_rst) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign o_expire = i_en && (count_q >= LAST);

endmodule

// File: rtl/serv_mem_arbiter.sv
// Registered 2:1 arbiter sharing one Wishbone-style memory port between the
// SERV instruction and data buses, with optional stall watchdog.
module serv_mem_arbiter
    import serv_mem_arbiter_pkg::*;
#(
    parameter logic FAIR    = 1'b0,
    parameter int   TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        i_rst,
    input  logic [31:0] i_ibus_adr,
    input  logic        i_ibus_cyc,
    output logic [31:0] o_ibus_rdt,
    output logic        o_ibus_ack,
    input  logic [31:0] i_dbus_adr,
    input  logic [31:0] i_dbus_dat,
    input  logic [3:0]  i_dbus_sel,
    input  logic        i_dbus_we,
    input  logic        i_dbus_cyc,
    output logic [31:0] o_dbus_rdt,
    output logic        o_dbus_ack,
    output logic [31:0] o_adr,
    output logic [31:0] o_dat,
    output logic [3:0]  o_sel,
    output logic        o_we,
    output logic        o_cyc,
    input  logic [31:0] i_rdt,
    input  logic        i_ack,
    output logic        o_timeout
);

    arb_state_e  state_d, state_q;
    logic        gnt_d, gnt_q;
    logic        last_d, last_q;
    logic [31:0] adr_d, adr_q;
    logic [31:0] dat_d, dat_q;
    logic [3:0]  sel_d, sel_q;
    logic        we_d, we_q;
    logic        cyc_d, cyc_q;
    logic [31:0] ibus_rdt_d, ibus_rdt_q;
    logic [31:0] dbus_rdt_d, dbus_rdt_q;
    logic        ibus_ack_d, ibus_ack_q;
    logic        dbus_ack_d, dbus_ack_q;
    logic        timeout_d, timeout_q;

    logic        win_s;
    logic        req_cyc_s;
    logic        done_s;
    logic [31:0] rsp_rdt_s;
    logic        wdt_clear_s;
    logic        wdt_en_s;
    logic        wdt_expire_s;

    // Next-state and next-output logic for the IDLE/BUSY/ACK handshake
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        we_d        = we_q;
        cyc_d       = cyc_q;
        ibus_rdt_d  = ibus_rdt_q;
        dbus_rdt_d  = dbus_rdt_q;
        ibus_ack_d  = 1'b0;
        dbus_ack_d  = 1'b0;
        timeout_d   = 1'b0;
        wdt_clear_s = 1'b0;
        wdt_en_s    = 1'b0;
        done_s      = 1'b0;
        rsp_rdt_s   = 32'h0000_0000;
        win_s       = arb_pick(i_ibus_cyc, i_dbus_cyc, FAIR, last_q);
        req_cyc_s   = (gnt_q == GNT_D) ? i_dbus_cyc : i_ibus_cyc;

        case (state_q)
            ARB_IDLE: begin
                if (i_ibus_cyc || i_dbus_cyc) begin
                    gnt_d       = win_s;
                    last_d      = win_s;
                    cyc_d       = 1'b1;
                    state_d     = ARB_BUSY;
                    wdt_clear_s = 1'b1;
                    if (win_s == GNT_D) begin
                        adr_d = i_dbus_adr;
                        dat_d = i_dbus_dat;
                        sel_d = i_dbus_sel;
                        we_d  = i_dbus_we;
                    end else begin
                        adr_d = i_ibus_adr;
                        dat_d = 32'h0000_0000;
                        sel_d = SEL_WORD;
                        we_d  = 1'b0;
                    end
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_BUSY: begin
                wdt_en_s = ~i_ack;
                // A real ack beats both abort and watchdog expiry
                if (i_ack) begin
                    done_s    = 1'b1;
                    rsp_rdt_s = i_rdt;
                end else if (!req_cyc_s) begin
                    cyc_d   = 1'b0;
                    state_d = ARB_IDLE;
                end else if (wdt_expire_s) begin
                    done_s    = 1'b1;
                    rsp_rdt_s = 32'h0000_0000;
                    timeout_d = 1'b1;
                end else begin
                    state_d = ARB_BUSY;
                end
                if (done_s) begin
                    cyc_d   = 1'b0;
                    state_d = ARB_ACK;
                    if (gnt_q == GNT_D) begin
                        dbus_rdt_d = rsp_rdt_s;
                        dbus_ack_d = 1'b1;
                    end else begin
                        ibus_rdt_d = rsp_rdt_s;
                        ibus_ack_d = 1'b1;
                    end
                end else begin
                    done_s = 1'b0;
                end
            end
            // Requester drops cyc on this edge; never re-grant from here
            ARB_ACK: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q    <= ARB_IDLE;
            gnt_q      <= GNT_I;
            last_q     <= GNT_I;
            adr_q      <= 32'h0000_0000;
            dat_q      <= 32'h0000_0000;
            sel_q      <= 4'h0;
            we_q       <= 1'b0;
            cyc_q      <= 1'b0;
            ibus_rdt_q <= 32'h0000_0000;
            dbus_rdt_q <= 32'h0000_0000;
            ibus_ack_q <= 1'b0;
            dbus_ack_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            sel_q      <= sel_d;
            we_q       <= we_d;
            cyc_q      <= cyc_d;
            ibus_rdt_q <= ibus_rdt_d;
            dbus_rdt_q <= dbus_rdt_d;
            ibus_ack_q <= ibus_ack_d;
            dbus_ack_q <= dbus_ack_d;
            timeout_q  <= timeout_d;
        end
    end

    generate
        if (TIMEOUT > 0) begin : g_wdt
            serv_arb_wdt #(
                .TIMEOUT (TIMEOUT)
            ) u_wdt (
                .clk      (clk),
                .i_rst    (i_rst),
                .i_clear  (wdt_clear_s),
                .i_en     (wdt_en_s),
                .o_expire (wdt_expire_s)
            );
        end else begin : g_no_wdt
            logic wdt_unused_s;
            assign wdt_expire_s = 1'b0;
            assign wdt_unused_s = wdt_clear_s ^ wdt_en_s;
        end
    endgenerate

    assign o_adr      = adr_q;
    assign o_dat      = dat_q;
    assign o_sel      = sel_q;
    assign o_we       = we_q;
    assign o_cyc      = cyc_q;
    assign o_ibus_rdt = ibus_rdt_q;
    assign o_ibus_ack = ibus_ack_q;
    assign o_dbus_rdt = dbus_rdt_q;
    assign o_dbus_ack = dbus_ack_q;
    assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_serv_mem_arbiter.sv
// Directed bench: dut_a (FAIR=0, no watchdog) and dut_b (FAIR=1, TIMEOUT=8),
// one stimulus set steered to whichever instance is under test.
module tb_serv_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        use_b;
    logic [31:0] ibus_adr, dbus_adr, dbus_dat, rdt;
    logic [3:0]  dbus_sel;
    logic        ibus_cyc, dbus_cyc, dbus_we, ack;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    logic [31:0] a_ibus_rdt, a_dbus_rdt, a_adr, a_dat, b_ibus_rdt, b_dbus_rdt, b_adr, b_dat;
    logic [3:0]  a_sel, b_sel;
    logic        a_ibus_ack, a_dbus_ack, a_we, a_cyc, a_to;
    logic        b_ibus_ack, b_dbus_ack, b_we, b_cyc, b_to;

    serv_mem_arbiter #(.FAIR(1'b0), .TIMEOUT(0)) dut_a (
        .clk(clk), .i_rst(rst),
        .i_ibus_adr(ibus_adr), .i_ibus_cyc(ibus_cyc & ~use_b),
        .o_ibus_rdt(a_ibus_rdt), .o_ibus_ack(a_ibus_ack),
        .i_dbus_adr(dbus_adr), .i_dbus_dat(dbus_dat), .i_dbus_sel(dbus_sel),
        .i_dbus_we(dbus_we), .i_dbus_cyc(dbus_cyc & ~use_b),
        .o_dbus_rdt(a_dbus_rdt), .o_dbus_ack(a_dbus_ack),
        .o_adr(a_adr), .o_dat(a_dat), .o_sel(a_sel), .o_we(a_we), .o_cyc(a_cyc),
        .i_rdt(rdt), .i_ack(ack & ~use_b), .o_timeout(a_to)
    );

    serv_mem_arbiter #(.FAIR(1'b1), .TIMEOUT(8)) dut_b (
        .clk(clk), .i_rst(rst),
        .i_ibus_adr(ibus_adr), .i_ibus_cyc(ibus_cyc & use_b),
        .o_ibus_rdt(b_ibus_rdt), .o_ibus_ack(b_ibus_ack),
        .i_dbus_adr(dbus_adr), .i_dbus_dat(dbus_dat), .i_dbus_sel(dbus_sel),
        .i_dbus_we(dbus_we), .i_dbus_cyc(dbus_cyc & use_b),
        .o_dbus_rdt(b_dbus_rdt), .o_dbus_ack(b_dbus_ack),
        .o_adr(b_adr), .o_dat(b_dat), .o_sel(b_sel), .o_we(b_we), .o_cyc(b_cyc),
        .i_rdt(rdt), .i_ack(ack & use_b), .o_timeout(b_to)
    );

    wire [31:0] ob_ibus_rdt = use_b ? b_ibus_rdt : a_ibus_rdt;
    wire [31:0] ob_dbus_rdt = use_b ? b_dbus_rdt : a_dbus_rdt;
    wire [31:0] ob_adr      = use_b ? b_adr : a_adr;
    wire [31:0] ob_dat      = use_b ? b_dat : a_dat;
    wire [3:0]  ob_sel      = use_b ? b_sel : a_sel;
    wire        ob_ibus_ack = use_b ? b_ibus_ack : a_ibus_ack;
    wire        ob_dbus_ack = use_b ? b_dbus_ack : a_dbus_ack;
    wire        ob_we       = use_b ? b_we : a_we;
    wire        ob_cyc      = use_b ? b_cyc : a_cyc;
    wire        ob_to       = use_b ? b_to : a_to;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=stuck expected=finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        rst = 1'b1; use_b = 1'b0; ack = 1'b0; rdt = 32'h0;
        ibus_adr = 32'h0; ibus_cyc = 1'b0;
        dbus_adr = 32'h0; dbus_dat = 32'h0; dbus_sel = 4'h0; dbus_we = 1'b0; dbus_cyc = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Reset values on both instances
        chk("rst_a_cyc_adr", {a_cyc, a_adr[30:0]}, 32'h0);
        chk("rst_a_dat", a_dat, 32'h0);
        chk("rst_a_sel_we_ack_to", {a_sel, a_we, a_ibus_ack, a_dbus_ack, a_to}, 32'h0);
        chk("rst_a_rdts", a_ibus_rdt | a_dbus_rdt, 32'h0);
        chk("rst_b_misc", {b_cyc, b_sel, b_we, b_ibus_ack, b_dbus_ack, b_to}, 32'h0);

        // Single ibus fetch
        ibus_cyc = 1'b1; ibus_adr = 32'h0000_0100;
        tick();
        chk("fetch_cyc", ob_cyc, 1);
        chk("fetch_adr", ob_adr, 32'h100);
        chk("fetch_we_sel", {ob_we, ob_sel}, 32'h0F);
        tick();
        chk("fetch_wait_ack", ob_ibus_ack, 0);
        ack = 1'b1; rdt = 32'h0000_0013;
        tick();
        chk("fetch_iack", ob_ibus_ack, 1);
        chk("fetch_irdt", ob_ibus_rdt, 32'h13);
        chk("fetch_dack", ob_dbus_ack, 0);
        chk("fetch_cyc_drop", ob_cyc, 0);
        ibus_cyc = 1'b0; ack = 1'b0;
        tick();
        chk("fetch_iack_once", ob_ibus_ack, 0);
        chk("fetch_irdt_hold", ob_ibus_rdt, 32'h13);

        // Simultaneous requests, FAIR=0: dbus first every time
        for (int r = 0; r < 3; r++) begin
            ibus_cyc = 1'b1; ibus_adr = 32'h0000_0200;
            dbus_cyc = 1'b1; dbus_adr = 32'h0000_3000 + 32'(r); dbus_sel = 4'hF; dbus_we = 1'b0;
            tick();
            chk("prio_d_first", ob_adr, 32'h0000_3000 + 32'(r));
            ack = 1'b1; rdt = 32'h0000_00D0 + 32'(r);
            tick();
            chk("prio_dack", {ob_dbus_ack, ob_ibus_ack}, 32'h2);
            chk("prio_drdt", ob_dbus_rdt, 32'h0000_00D0 + 32'(r));
            dbus_cyc = 1'b0; ack = 1'b0;
            tick();
            chk("prio_ack_no_regrant", ob_cyc, 0);
            tick();
            chk("prio_i_second", {ob_cyc, ob_adr[30:0]}, 32'h8000_0200);
            ack = 1'b1; rdt = 32'h0000_0011;
            tick();
            chk("prio_iack", {ob_ibus_ack, ob_dbus_ack}, 32'h2);
            ibus_cyc = 1'b0; ack = 1'b0;
            tick();
        end

        // dbus store, stalled 5 cycles
        dbus_cyc = 1'b1; dbus_adr = 32'h0000_2000; dbus_dat = 32'hCAFE_BABE; dbus_sel = 4'h3; dbus_we = 1'b1;
        tick();
        for (int w = 0; w < 6; w++) begin
            chk("store_adr", ob_adr, 32'h2000);
            chk("store_dat", ob_dat, 32'hCAFE_BABE);
            chk("store_cyc_we_sel", {ob_cyc, ob_we, ob_sel}, 32'h33);
            if (w < 5) tick();
        end
        ack = 1'b1; rdt = 32'h0000_0055;
        tick();
        chk("store_dack", {ob_dbus_ack, ob_ibus_ack, ob_cyc}, 32'h4);
        ack = 1'b0;
        tick();
        chk("store_no_regrant", {ob_dbus_ack, ob_cyc}, 32'h0);
        dbus_cyc = 1'b0; dbus_we = 1'b0;
        tick();
        chk("store_idle", ob_cyc, 0);

        // FAIR=1 instance: one dbus access makes last=dbus
        use_b = 1'b1;
        dbus_cyc = 1'b1; dbus_adr = 32'h0000_5000; dbus_sel = 4'hF;
        tick();
        ack = 1'b1; rdt = 32'h0000_0001;
        tick();
        chk("fair_setup_dack", ob_dbus_ack, 1);
        dbus_cyc = 1'b0; ack = 1'b0;
        tick();
        ibus_adr = 32'h0000_0400;
        for (int r = 0; r < 10; r++) begin
            ibus_cyc = 1'b1; dbus_cyc = 1'b1;
            tick();
            chk("fair_grant_adr", ob_adr, (r % 2 == 0) ? 32'h0000_0400 : 32'h0000_5000);
            ack = 1'b1; rdt = 32'h0000_0A00 + 32'(r);
            tick();
            chk("fair_acks", {ob_ibus_ack, ob_dbus_ack}, (r % 2 == 0) ? 32'h2 : 32'h1);
            ibus_cyc = 1'b0; dbus_cyc = 1'b0; ack = 1'b0;
            tick();
        end

        // Watchdog on dut_b: no ack for 8 BUSY cycles
        ibus_cyc = 1'b1; ibus_adr = 32'h0000_0600; rdt = 32'hDEAD_BEEF;
        tick();
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk("wdt_pending", {ob_cyc, ob_to, ob_ibus_ack}, 32'h4);
        end
        tick();
        chk("wdt_fire", {ob_cyc, ob_to, ob_ibus_ack}, 32'h3);
        chk("wdt_rdt_zero", ob_ibus_rdt, 32'h0);
        ibus_cyc = 1'b0; ack = 1'b1; rdt = 32'h0000_0077;
        tick();
        chk("wdt_to_pulse", {ob_to, ob_ibus_ack}, 32'h0);
        tick();
        chk("late_ack_ignored", {ob_ibus_ack, ob_dbus_ack, ob_cyc}, 32'h0);
        chk("late_ack_rdt", ob_ibus_rdt, 32'h0);
        ack = 1'b0;

        // Reset in BUSY on dut_a, then a fresh fetch
        use_b = 1'b0;
        ibus_cyc = 1'b1; ibus_adr = 32'h0000_0700;
        tick();
        chk("rbusy_cyc", ob_cyc, 1);
        rst = 1'b1; ack = 1'b1; rdt = 32'h0000_0099;
        tick();
        chk("rbusy_cleared", {ob_cyc, ob_ibus_ack}, 32'h0);
        chk("rbusy_rdt", ob_ibus_rdt, 32'h0);
        rst = 1'b0; ack = 1'b0; ibus_adr = 32'h0000_0800;
        tick();
        chk("rbusy_regrant", {ob_cyc, ob_adr[30:0]}, 32'h8000_0800);
        ack = 1'b1; rdt = 32'h0000_0042;
        tick();
        chk("rbusy_iack", ob_ibus_ack, 1);
        chk("rbusy_irdt", ob_ibus_rdt, 32'h42);
        ibus_cyc = 1'b0; ack = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
